// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and polarity helper for the hex display bank.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    // Active-low {g..a} codes, entry n is hex digit n (listed F down to 0).
    localparam logic [15:0][SEG_W-1:0] SEG_CODE = {
        7'h0E, 7'h06, 7'h21, 7'h27, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // All segments dark, active-low form.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Map an active-low pattern to the board polarity.
    function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] code,
                                                     input logic active_low);
        return active_low ? code : ~code;
    endfunction

endpackage

// File: rtl/hex_display_bank_if.sv
// Load/value/control bus into the display bank and its segment outputs.
interface hex_display_bank_if #(
    parameter int unsigned NDIGITS = 6
) ();
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic                   lz_en;
    logic [NDIGITS-1:0]     blink_mask;
    logic [7*NDIGITS-1:0]   seg;
    logic                   blink_phase;

    modport master (
        output load, value, lz_en, blink_mask,
        input  seg, blink_phase
    );

    modport slave (
        input  load, value, lz_en, blink_mask,
        output seg, blink_phase
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment code lookup.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] code_c
);

    // Table lookup with board polarity applied.
    always_comb begin
        code_c = seg_polarity(SEG_CODE[nibble], ACTIVE_LOW);
    end

endmodule

// File: rtl/hex_display_bank.sv
// Registered multi-digit hex display driver with leading-zero suppression and blink.
module hex_display_bank
    import seg7_pkg::*;
#(
    parameter int unsigned NDIGITS    = 6,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    hex_display_bank_if.slave bus
);

    localparam int unsigned          PW       = $clog2(BLINK_DIV);
    localparam int unsigned          VW       = 4 * NDIGITS;
    localparam int unsigned          SW       = SEG_W * NDIGITS;
    localparam logic [PW-1:0]        PRE_LAST = PW'(BLINK_DIV - 1);
    localparam logic [SEG_W-1:0]     BLANK_P  = seg_polarity(SEG_BLANK, ACTIVE_LOW);

    logic [VW-1:0]      value_q;
    logic [PW-1:0]      pre_q;
    logic               blink_q;
    logic [SW-1:0]      seg_q;
    logic [SW-1:0]      seg_d;
    logic [NDIGITS:0]   zero_run;
    logic [NDIGITS-1:0] lz_blank;
    logic [SEG_W-1:0]   dec_c [NDIGITS];

    // Capture the display value on each load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (bus.load) begin
            value_q <= bus.value;
        end
    end

    // Free-running prescaler; blink phase flips on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            blink_q <= 1'b0;
        end else if (pre_q == PRE_LAST) begin
            pre_q   <= '0;
            blink_q <= ~blink_q;
        end else begin
            pre_q   <= pre_q + PW'(1);
        end
    end

    // zero_run[i] is set when every nibble from the MSD down to i is zero.
    assign zero_run[NDIGITS] = 1'b1;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        seg7_decode #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_dec (
            .nibble (value_q[4*g +: 4]),
            .code_c (dec_c[g])
        );

        assign zero_run[g] = zero_run[g+1] & (value_q[4*g +: 4] == 4'h0);

        if (g == 0) begin : g_lsd
            assign lz_blank[g] = 1'b0;
        end else begin : g_upper
            assign lz_blank[g] = bus.lz_en & zero_run[g];
        end

        // Priority: blink-dark, then leading-zero blank, then decoded digit.
        assign seg_d[SEG_W*g +: SEG_W] =
            (blink_q && bus.blink_mask[g]) ? BLANK_P :
            lz_blank[g]                    ? BLANK_P :
                                             dec_c[g];
    end

    // Segment register refreshed every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {NDIGITS{BLANK_P}};
        end else begin
            seg_q <= seg_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.blink_phase = blink_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench: active-low and inverted-polarity instances driven in lockstep.
module tb_hex_display_bank;

    localparam int unsigned ND = 6;
    localparam int unsigned SW = 7 * ND;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hex_display_bank_if #(.NDIGITS(ND)) if_a ();
    hex_display_bank_if #(.NDIGITS(ND)) if_b ();

    assign if_b.load       = if_a.load;
    assign if_b.value      = if_a.value;
    assign if_b.lz_en      = if_a.lz_en;
    assign if_b.blink_mask = if_a.blink_mask;

    hex_display_bank #(.NDIGITS(ND), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    hex_display_bank #(.NDIGITS(ND), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    localparam logic [6:0] CODE_T [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [23:0]   v;
        logic          lz;
        logic [SW-1:0] exp;
    } vec_t;

    vec_t           tab [10];
    logic [SW-1:0]  sb_q [$];

    // Reference active-low segment image for given inputs and darkness.
    function automatic logic [SW-1:0] model(input logic [23:0] v, input logic lz,
                                            input logic [5:0] mask, input logic dark);
        logic [SW-1:0] r;
        logic          above;
        logic [3:0]    nib;
        r     = '0;
        above = 1'b1;
        for (int i = ND - 1; i >= 0; i--) begin
            nib   = v[4*i +: 4];
            above = above && (nib == 4'h0);
            if (dark && mask[i])
                r[7*i +: 7] = 7'h7F;
            else if (lz && above && (i != 0))
                r[7*i +: 7] = 7'h7F;
            else
                r[7*i +: 7] = CODE_T[nib];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare both instances against one active-low expectation.
    task automatic check_both(input string name, input logic [SW-1:0] exp);
        check({name, "/al"}, if_a.seg, exp);
        check({name, "/ah"}, if_b.seg, ~exp);
    endtask

    initial begin
        logic [SW-1:0] exp;
        logic [23:0]   b2b [4];

        tab[0] = '{24'h12AB3F, 1'b0, {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E}};
        tab[1] = '{24'h000A05, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12}};
        tab[2] = '{24'h000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tab[3] = '{24'h000000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        tab[4] = '{24'h876543, 1'b1, {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30}};
        tab[5] = '{24'hFEDC98, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h27, 7'h10, 7'h00}};
        tab[6] = '{24'h000001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}};
        tab[7] = '{24'h100000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        tab[8] = '{24'h000008, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00}};
        tab[9] = '{24'h0C0B00, 1'b1, {7'h7F, 7'h27, 7'h40, 7'h03, 7'h40, 7'h40}};

        if_a.load       = 1'b0;
        if_a.value      = '0;
        if_a.lz_en      = 1'b0;
        if_a.blink_mask = '0;

        // Reset hold and first post-release update.
        repeat (2) @(negedge clk);
        check_both("reset_seg", {ND{7'h7F}});
        check("reset_phase", SW'(if_a.blink_phase), SW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_both("post_reset_zero", {ND{7'h40}});

        // Table vectors: push on drive, pop two edges later, then confirm hold.
        foreach (tab[k]) begin
            @(negedge clk);
            if_a.value = tab[k].v;
            if_a.lz_en = tab[k].lz;
            if_a.load  = 1'b1;
            sb_q.push_back(tab[k].exp);
            @(negedge clk);
            if_a.load  = 1'b0;
            if_a.value = ~tab[k].v;
            @(negedge clk);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                exp = sb_q.pop_front();
                check_both($sformatf("vec%0d", k), exp);
            end
            @(negedge clk);
            check_both($sformatf("vec%0d_hold", k), exp);
        end

        // Back-to-back loads: every value shows up one edge behind value_q.
        b2b[0] = 24'h111111; b2b[1] = 24'h0ABCDE; b2b[2] = 24'h000F00; b2b[3] = 24'h987654;
        if_a.lz_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_empty: got 0 entries expected 1");
                end else begin
                    check_both($sformatf("b2b%0d", k - 2), sb_q.pop_front());
                end
            end
            if (k < 4) begin
                if_a.load  = 1'b1;
                if_a.value = b2b[k];
                sb_q.push_back(model(b2b[k], 1'b1, 6'b0, 1'b0));
            end else begin
                if_a.load = 1'b0;
            end
        end

        // Blink: reset asynchronously mid-run, then track phase edge by edge.
        @(negedge clk);
        if_a.load       = 1'b1;
        if_a.value      = 24'h123456;
        if_a.lz_en      = 1'b0;
        if_a.blink_mask = 6'b000011;
        #1 rst_n = 1'b0;
        #1;
        check_both("async_reset_seg", {ND{7'h7F}});
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if_a.load = 1'b0;
                check_both("blink_first_zero", model(24'h0, 1'b0, 6'b000011, 1'b0));
            end else begin
                check_both($sformatf("blink_seg_n%0d", n),
                           model(24'h123456, 1'b0, 6'b000011, 1'(((n - 1) / 4) % 2)));
            end
            check($sformatf("blink_phase_n%0d", n), SW'(if_a.blink_phase), SW'((n / 4) % 2));
        end

        // Reset while blinking dark with a nonzero value.
        if_a.lz_en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_both("midblink_reset_seg", {ND{7'h7F}});
        check("midblink_reset_phase", SW'(if_a.blink_phase), SW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 1; m <= 5; m++) begin
            @(negedge clk);
            check_both($sformatf("rel_seg_m%0d", m),
                       model(24'h0, 1'b1, 6'b000011, 1'(((m - 1) / 4) % 2)));
            check($sformatf("rel_phase_m%0d", m), SW'(if_a.blink_phase), SW'((m / 4) % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
